// File: rtl/digt_i2c_tmp_slave.sv
// -----------------------------------------------------------------------------
// digt_i2c_tmp_slave
//
// I2C target that stands in for the on-board digital temperature sensor.
// 7-bit address, 2-bit pointer register, 16-bit registers:
//   pointer 0 : live temperature (read-only, from tmp_value)
//   pointer 1 : config
//   pointer 2 : TLOW
//   pointer 3 : THIGH
// SCL/SDA are oversampled on sys_clk (2-FF synchroniser, FILTER_LEN hold
// filter, edge detect). The block never stretches SCL and never drives a
// clock; SDA is open-drain through i2c_sda_oe.
//
// Ports
//   sys_clk       in   20 MHz system clock
//   rst           in   synchronous active-high reset
//   i2c_scl_in    in   bus SCL (asynchronous)
//   i2c_sda_in    in   bus SDA (asynchronous)
//   i2c_sda_oe    out  1 = pull SDA low
//   tmp_value     in   live temperature word, 12-bit left-justified
//   cfg_reg       out  config register
//   tlow_reg      out  TLOW register
//   thigh_reg     out  THIGH register
//   reg_wr_pulse  out  one-cycle pulse when a register write commits
//   busy          out  high from address match to STOP or mismatch
//   alert         out  (only with DIGT_I2C_SLAVE_ALERT_EN) hysteresis alert
//   debug_signal  out  {state, bit_cnt, pointer, shift, 14'd0}
//
// Build option
//   DIGT_I2C_SLAVE_ALERT_EN : adds the alert output and its comparator.
// -----------------------------------------------------------------------------
module digt_i2c_tmp_slave #(
   parameter logic [6:0]  SLAVE_ADDR = 7'h48,
   parameter int          FILTER_LEN = 3,
   parameter logic [15:0] CONFIG_RST = 16'h60A0,
   parameter logic [15:0] TLOW_RST   = 16'h4B00,
   parameter logic [15:0] THIGH_RST  = 16'h5000
) (
   input  logic        sys_clk,
   input  logic        rst,
   input  logic        i2c_scl_in,
   input  logic        i2c_sda_in,
   output logic        i2c_sda_oe,
   input  logic [15:0] tmp_value,
   output logic [15:0] cfg_reg,
   output logic [15:0] tlow_reg,
   output logic [15:0] thigh_reg,
   output logic        reg_wr_pulse,
   output logic        busy,
`ifdef DIGT_I2C_SLAVE_ALERT_EN
   output logic        alert,
`endif
   output logic [31:0] debug_signal
);

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_ADDR      = 4'd1,
      ST_ADDR_ACK  = 4'd2,
      ST_PTR       = 4'd3,
      ST_PTR_ACK   = 4'd4,
      ST_WDATA     = 4'd5,
      ST_WDATA_ACK = 4'd6,
      ST_RDATA     = 4'd7,
      ST_RDATA_ACK = 4'd8
   } state_t;

   localparam logic [2:0] FILT_MAX = 3'(FILTER_LEN - 1);

   // ---------------------------------------------------------------------------
   // Input path: synchroniser, hold filter, edge detect
   // ---------------------------------------------------------------------------
   logic [1:0] scl_sync, sda_sync;
   logic [2:0] scl_cnt, sda_cnt;
   logic       scl_f, sda_f, scl_d, sda_d;

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         scl_sync <= 2'b11;
         sda_sync <= 2'b11;
         scl_cnt  <= '0;
         sda_cnt  <= '0;
         scl_f    <= 1'b1;
         sda_f    <= 1'b1;
         scl_d    <= 1'b1;
         sda_d    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[0], i2c_scl_in};
         sda_sync <= {sda_sync[0], i2c_sda_in};
         scl_d    <= scl_f;
         sda_d    <= sda_f;
         // The filtered level only follows after FILTER_LEN consecutive
         // samples that disagree with it; any agreeing sample restarts the run.
         if (scl_sync[1] == scl_f) begin
            scl_cnt <= '0;
         end else if (scl_cnt == FILT_MAX) begin
            scl_f   <= scl_sync[1];
            scl_cnt <= '0;
         end else begin
            scl_cnt <= scl_cnt + 3'd1;
         end
         if (sda_sync[1] == sda_f) begin
            sda_cnt <= '0;
         end else if (sda_cnt == FILT_MAX) begin
            sda_f   <= sda_sync[1];
            sda_cnt <= '0;
         end else begin
            sda_cnt <= sda_cnt + 3'd1;
         end
      end
   end

   logic scl_rise, scl_fall, start_det, stop_det;
   assign scl_rise  = scl_f & ~scl_d;
   assign scl_fall  = ~scl_f & scl_d;
   assign start_det = ~sda_f & sda_d & scl_f & scl_d;
   assign stop_det  = sda_f & ~sda_d & scl_f & scl_d;

   // ---------------------------------------------------------------------------
   // Protocol FSM and datapath registers
   // ---------------------------------------------------------------------------
   state_t      state, state_nxt;
   logic [3:0]  bit_cnt, bit_cnt_nxt;
   logic [7:0]  shift, shift_nxt;
   logic [1:0]  pointer, pointer_nxt;
   logic [15:0] rd_buf, rd_buf_nxt;
   logic        rd_lsb, rd_lsb_nxt;     // next read byte is the LSB
   logic        wr_lsb, wr_lsb_nxt;     // next write byte is the LSB
   logic [7:0]  wr_msb, wr_msb_nxt;
   logic        ack_phase, ack_phase_nxt;
   logic        rw, rw_nxt;
   logic        sda_oe, sda_oe_nxt;
   logic        busy_q, busy_nxt;
   logic [15:0] cfg_q, cfg_nxt, tlow_q, tlow_nxt, thigh_q, thigh_nxt;
   logic        pulse_nxt, pulse_q;
   logic [7:0]  rx_byte, nb_byte;
   logic [15:0] sel_word;
   logic        byte_done;

   assign rx_byte   = {shift[6:0], sda_f};
   assign byte_done = scl_rise && (bit_cnt == 4'd7);
   assign nb_byte   = rd_lsb ? rd_buf[7:0] : rd_buf[15:8];

   always_comb begin
      sel_word = tmp_value;
      case (pointer)
         2'd1:    sel_word = cfg_q;
         2'd2:    sel_word = tlow_q;
         2'd3:    sel_word = thigh_q;
         default: sel_word = tmp_value;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         bit_cnt   <= '0;
         shift     <= '0;
         pointer   <= '0;
         rd_buf    <= '0;
         rd_lsb    <= 1'b0;
         wr_lsb    <= 1'b0;
         wr_msb    <= '0;
         ack_phase <= 1'b0;
         rw        <= 1'b0;
         sda_oe    <= 1'b0;
         busy_q    <= 1'b0;
         cfg_q     <= CONFIG_RST;
         tlow_q    <= TLOW_RST;
         thigh_q   <= THIGH_RST;
         pulse_q   <= 1'b0;
      end else begin
         state     <= state_nxt;
         bit_cnt   <= bit_cnt_nxt;
         shift     <= shift_nxt;
         pointer   <= pointer_nxt;
         rd_buf    <= rd_buf_nxt;
         rd_lsb    <= rd_lsb_nxt;
         wr_lsb    <= wr_lsb_nxt;
         wr_msb    <= wr_msb_nxt;
         ack_phase <= ack_phase_nxt;
         rw        <= rw_nxt;
         sda_oe    <= sda_oe_nxt;
         busy_q    <= busy_nxt;
         cfg_q     <= cfg_nxt;
         tlow_q    <= tlow_nxt;
         thigh_q   <= thigh_nxt;
         pulse_q   <= pulse_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      bit_cnt_nxt   = bit_cnt;
      shift_nxt     = shift;
      pointer_nxt   = pointer;
      rd_buf_nxt    = rd_buf;
      rd_lsb_nxt    = rd_lsb;
      wr_lsb_nxt    = wr_lsb;
      wr_msb_nxt    = wr_msb;
      ack_phase_nxt = ack_phase;
      rw_nxt        = rw;
      sda_oe_nxt    = sda_oe;
      busy_nxt      = busy_q;
      cfg_nxt       = cfg_q;
      tlow_nxt      = tlow_q;
      thigh_nxt     = thigh_q;
      pulse_nxt     = 1'b0;

      if (start_det) begin
         state_nxt   = ST_ADDR;
         bit_cnt_nxt = '0;
         sda_oe_nxt  = 1'b0;
      end else if (stop_det) begin
         state_nxt   = ST_IDLE;
         bit_cnt_nxt = '0;
         sda_oe_nxt  = 1'b0;
         busy_nxt    = 1'b0;
      end else begin
         case (state)
            ST_ADDR, ST_PTR, ST_WDATA: begin
               if (scl_rise) begin
                  shift_nxt   = rx_byte;
                  bit_cnt_nxt = bit_cnt + 4'd1;
               end
               if (byte_done) begin
                  bit_cnt_nxt   = '0;
                  ack_phase_nxt = 1'b0;
                  if (state == ST_ADDR) begin
                     if (rx_byte[7:1] == SLAVE_ADDR) begin
                        state_nxt  = ST_ADDR_ACK;
                        busy_nxt   = 1'b1;
                        rw_nxt     = rx_byte[0];
                        rd_lsb_nxt = 1'b0;
                        if (rx_byte[0]) rd_buf_nxt = sel_word;
                     end else begin
                        state_nxt = ST_IDLE;
                        busy_nxt  = 1'b0;
                     end
                  end else if (state == ST_PTR) begin
                     state_nxt   = ST_PTR_ACK;
                     pointer_nxt = rx_byte[1:0];
                     wr_lsb_nxt  = 1'b0;
                  end else begin
                     state_nxt = ST_WDATA_ACK;
                     if (!wr_lsb) begin
                        wr_msb_nxt = rx_byte;
                        wr_lsb_nxt = 1'b1;
                     end else begin
                        wr_lsb_nxt = 1'b0;
                        // Pointer 0 is the live temperature: ACK, but drop it.
                        case (pointer)
                           2'd1: begin cfg_nxt   = {wr_msb, rx_byte}; pulse_nxt = 1'b1; end
                           2'd2: begin tlow_nxt  = {wr_msb, rx_byte}; pulse_nxt = 1'b1; end
                           2'd3: begin thigh_nxt = {wr_msb, rx_byte}; pulse_nxt = 1'b1; end
                           default: ;
                        endcase
                     end
                  end
               end
            end

            ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
               if (scl_fall) begin
                  if (!ack_phase) begin
                     sda_oe_nxt    = 1'b1;
                     ack_phase_nxt = 1'b1;
                  end else begin
                     bit_cnt_nxt = '0;
                     if (state == ST_ADDR_ACK && rw) begin
                        // The fall that ends the ACK is also the fall on which
                        // the first read bit has to appear on the bus.
                        state_nxt  = ST_RDATA;
                        shift_nxt  = rd_buf[15:8];
                        sda_oe_nxt = ~rd_buf[15];
                     end else if (state == ST_ADDR_ACK) begin
                        state_nxt  = ST_PTR;
                        sda_oe_nxt = 1'b0;
                     end else begin
                        state_nxt  = ST_WDATA;
                        sda_oe_nxt = 1'b0;
                     end
                  end
               end
            end

            ST_RDATA: begin
               if (scl_rise) begin
                  shift_nxt   = {shift[6:0], 1'b0};
                  bit_cnt_nxt = bit_cnt + 4'd1;
                  if (bit_cnt == 4'd7) begin
                     state_nxt     = ST_RDATA_ACK;
                     bit_cnt_nxt   = '0;
                     ack_phase_nxt = 1'b0;
                  end
               end else if (scl_fall) begin
                  sda_oe_nxt = ~shift[7];
               end
            end

            ST_RDATA_ACK: begin
               // ack_phase here marks "master ACKed, next byte pending".
               if (scl_rise) begin
                  if (!sda_f) begin
                     ack_phase_nxt = 1'b1;
                     if (!rd_lsb) begin
                        rd_lsb_nxt = 1'b1;
                     end else begin
                        rd_lsb_nxt = 1'b0;
                        rd_buf_nxt = sel_word;
                     end
                  end else begin
                     state_nxt  = ST_IDLE;
                     sda_oe_nxt = 1'b0;
                  end
               end else if (scl_fall) begin
                  if (!ack_phase) begin
                     sda_oe_nxt = 1'b0;
                  end else begin
                     state_nxt   = ST_RDATA;
                     bit_cnt_nxt = '0;
                     shift_nxt   = nb_byte;
                     sda_oe_nxt  = ~nb_byte[7];
                  end
               end
            end

            default: ;
         endcase
      end
   end

   assign i2c_sda_oe   = sda_oe;
   assign busy         = busy_q;
   assign cfg_reg      = cfg_q;
   assign tlow_reg     = tlow_q;
   assign thigh_reg    = thigh_q;
   assign reg_wr_pulse = pulse_q;
   assign debug_signal = {state, bit_cnt, pointer, shift, 14'd0};

`ifdef DIGT_I2C_SLAVE_ALERT_EN
   // Hysteresis comparator on the 12-bit signed temperature; config bit 1
   // enables it, and while masked the alert is held at 0.
   logic               alert_q;
   logic signed [11:0] t_s, hi_s, lo_s;
   assign t_s  = $signed(tmp_value[15:4]);
   assign hi_s = $signed(thigh_q[15:4]);
   assign lo_s = $signed(tlow_q[15:4]);

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         alert_q <= 1'b0;
      end else if (!cfg_q[1]) begin
         alert_q <= 1'b0;
      end else if (t_s >= hi_s) begin
         alert_q <= 1'b1;
      end else if (t_s < lo_s) begin
         alert_q <= 1'b0;
      end
   end

   assign alert = alert_q;
`endif

endmodule
